// File: rtl/bm_mac_rr_sched_if.sv
// Operand/result bundle between two requesters and the shared MAC scheduler.
// The master side is the producer pair; the slave side is the scheduler.
interface bm_mac_rr_sched_if #(
  parameter int unsigned BITS0 = 9,
  parameter int unsigned BITS2 = 2 * BITS0
);
  logic             req0;
  logic             req1;
  logic [BITS0-1:0] a0;
  logic [BITS0-1:0] a1;
  logic [BITS0-1:0] b0;
  logic [BITS0-1:0] b1;
  logic             v0;
  logic             v1;
  logic             last0;
  logic             last1;
  logic             gnt0;
  logic             gnt1;
  logic [BITS2-1:0] result;
  logic             res_valid;
  logic             res_id;
  logic             res_ovf;
  logic             abort;
  logic [3:0]       beat_cnt;

  modport master (
    output req0, req1, a0, a1, b0, b1, v0, v1, last0, last1,
    input  gnt0, gnt1, result, res_valid, res_id, res_ovf, abort, beat_cnt
  );

  modport slave (
    input  req0, req1, a0, a1, b0, b1, v0, v1, last0, last1,
    output gnt0, gnt1, result, res_valid, res_id, res_ovf, abort, beat_cnt
  );
endinterface

// File: rtl/bm_mac_rr_sched.sv
// Round-robin scheduler for one shared 9x9 multiply-accumulate datapath.
// Grants one of two requesters per burst and returns a tagged dot-product result.
module bm_mac_rr_sched #(
  parameter int unsigned BITS0     = 9,
  parameter int unsigned BITS2     = 18,
  parameter int unsigned MAX_BEATS = 8
) (
  input logic               clock,
  input logic               reset_n,
  bm_mac_rr_sched_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q,     state_d;
  logic               gnt0_q,      gnt0_d;
  logic               gnt1_q,      gnt1_d;
  logic               owner_q,     owner_d;
  logic               last_srv_q,  last_srv_d;
  logic [BITS2-1:0]   acc_q,       acc_d;
  logic               ovf_q,       ovf_d;
  logic [BITS2-1:0]   prod_q,      prod_d;
  logic               prod_v_q,    prod_v_d;
  logic [CNT_W-1:0]   beat_cnt_q,  beat_cnt_d;
  logic [BITS2-1:0]   result_q,    result_d;
  logic               res_id_q,    res_id_d;
  logic               res_ovf_q,   res_ovf_d;
  logic               res_valid_q, res_valid_d;
  logic               abort_q,     abort_d;

  // Operands of the current owner; the other port is never looked at while busy.
  logic               sel_req;
  logic               sel_v;
  logic               sel_last;
  logic [BITS0-1:0]   sel_a;
  logic [BITS0-1:0]   sel_b;
  logic [BITS2-1:0]   product;
  logic [BITS2:0]     acc_sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic               winner;
  logic               end_beat;

  assign sel_req  = owner_q ? bus.req1  : bus.req0;
  assign sel_v    = owner_q ? bus.v1    : bus.v0;
  assign sel_last = owner_q ? bus.last1 : bus.last0;
  assign sel_a    = owner_q ? bus.a1    : bus.a0;
  assign sel_b    = owner_q ? bus.b1    : bus.b0;

  assign product  = BITS2'(sel_a) * BITS2'(sel_b);
  assign acc_sum  = {1'b0, acc_q} + {1'b0, prod_q};
  assign cnt_inc  = beat_cnt_q + CNT_W'(1);
  assign end_beat = sel_v && (sel_last || (cnt_inc == CNT_W'(MAX_BEATS)));

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    owner_d     = owner_q;
    last_srv_d  = last_srv_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    prod_d      = prod_q;
    prod_v_d    = prod_v_q;
    beat_cnt_d  = beat_cnt_q;
    result_d    = result_q;
    res_id_d    = res_id_q;
    res_ovf_d   = res_ovf_q;
    res_valid_d = 1'b0;
    abort_d     = 1'b0;
    winner      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        prod_v_d = 1'b0;
        if (bus.req0 || bus.req1) begin
          winner     = (bus.req0 && bus.req1) ? ~last_srv_q : bus.req1;
          state_d    = S_BUSY;
          gnt0_d     = ~winner;
          gnt1_d     = winner;
          owner_d    = winner;
          last_srv_d = winner;
          acc_d      = '0;
          ovf_d      = 1'b0;
          beat_cnt_d = '0;
        end
      end

      S_BUSY: begin
        prod_v_d = 1'b0;
        if (prod_v_q) begin
          acc_d = acc_sum[BITS2-1:0];
          ovf_d = ovf_q | acc_sum[BITS2];
        end
        if (sel_v) begin
          prod_d     = product;
          prod_v_d   = 1'b1;
          beat_cnt_d = (beat_cnt_q == CNT_W'(MAX_BEATS)) ? beat_cnt_q : cnt_inc;
        end
        if (end_beat) begin
          state_d = S_FLUSH;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
        end else if (!sel_req) begin
          state_d  = S_IDLE;
          gnt0_d   = 1'b0;
          gnt1_d   = 1'b0;
          abort_d  = 1'b1;
          prod_v_d = 1'b0;
        end
      end

      S_FLUSH: begin
        if (prod_v_q) begin
          acc_d = acc_sum[BITS2-1:0];
          ovf_d = ovf_q | acc_sum[BITS2];
        end
        prod_v_d = 1'b0;
        state_d  = S_DONE;
      end

      S_DONE: begin
        result_d    = acc_q;
        res_id_d    = owner_q;
        res_ovf_d   = ovf_q;
        res_valid_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      owner_q     <= 1'b0;
      last_srv_q  <= 1'b1;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      beat_cnt_q  <= '0;
      result_q    <= '0;
      res_id_q    <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_valid_q <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      owner_q     <= owner_d;
      last_srv_q  <= last_srv_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      beat_cnt_q  <= beat_cnt_d;
      result_q    <= result_d;
      res_id_q    <= res_id_d;
      res_ovf_q   <= res_ovf_d;
      res_valid_q <= res_valid_d;
      abort_q     <= abort_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.result    = result_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_ovf   = res_ovf_q;
  assign bus.abort     = abort_q;
  assign bus.beat_cnt  = beat_cnt_q;

endmodule
